// File: rtl/display_pkg.sv
// Shared definitions for the front-panel display source arbiter:
// FSM state encoding, override-bank address map and flag bit positions.
package display_pkg;

  typedef enum logic [1:0] {
    ST_CPU      = 2'd0,
    ST_MON_PEND = 2'd1,
    ST_MON      = 2'd2,
    ST_LOCKOUT  = 2'd3
  } arb_state_t;

  localparam int BANK_DEPTH = 8;
  localparam int BANK_WIDTH = 16;

  // Override-bank map; narrow fields live in the low bits of their entry.
  localparam logic [2:0] BANK_A          = 3'd0;
  localparam logic [2:0] BANK_X          = 3'd1;
  localparam logic [2:0] BANK_Y          = 3'd2;
  localparam logic [2:0] BANK_SP         = 3'd3;
  localparam logic [2:0] BANK_PC         = 3'd4;
  localparam logic [2:0] BANK_MEM_LO     = 3'd5;
  localparam logic [2:0] BANK_MEM_HI     = 3'd6;
  localparam logic [2:0] BANK_FLAGS_DATA = 3'd7;

  // Bit positions within cpu_flags / led_flags.
  localparam int FLAG_ZERO  = 0;
  localparam int FLAG_CARRY = 1;
  localparam int FLAG_DEC   = 2;
  localparam int FLAG_IRQ   = 3;
  localparam int FLAG_NEG   = 4;
  localparam int FLAG_OVF   = 5;
  localparam int FLAG_DASH  = 6;
  localparam int FLAG_BRK   = 7;

  // Pick one 16-bit entry out of the flattened bank image.
  function automatic logic [15:0] bank_entry(input logic [127:0] flat,
                                             input logic [2:0]   idx);
    return flat[{idx, 4'b0000} +: 16];
  endfunction

endpackage

// File: rtl/override_bank.sv
// Monitor-owned 8x16 override register file. One write port; all entries
// are exposed at once so the top level can copy a whole frame in one edge.
module override_bank
  import display_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         we,
  input  logic [2:0]   waddr,
  input  logic [15:0]  wdata,
  output logic [127:0] rd_flat
);

  logic [BANK_WIDTH-1:0] mem_q [BANK_DEPTH];

  // Entry storage; contents persist across grants, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BANK_DEPTH; i++) mem_q[i] <= '0;
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  for (genvar g = 0; g < BANK_DEPTH; g++) begin : g_flat
    assign rd_flat[g*BANK_WIDTH +: BANK_WIDTH] = mem_q[g];
  end

endmodule

// File: rtl/display_source_arb.sv
// Front-panel display source arbiter. Once per scan frame chooses between
// the live CPU register taps and the monitor override bank, so a scan never
// mixes two sources. Optional idle-grant timeout with lockout is built when
// DISPLAY_ARB_TIMEOUT_EN is defined.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   CPU       | panel shows CPU taps; mon_req seen at frame_start -> pend
//   MON_PEND  | one frame of settling; grant issued if mon_req still high
//   MON       | monitor owns panel; bank copied to outputs each frame
//   LOCKOUT   | grant revoked on idle; waits for mon_req low (timeout only)
module display_source_arb
  import display_pkg::*;
#(
  parameter int HOLD_FRAMES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_start,
  input  logic        cpu_valid,
  input  logic [7:0]  cpu_a,
  input  logic [7:0]  cpu_x,
  input  logic [7:0]  cpu_y,
  input  logic [7:0]  cpu_data,
  input  logic [15:0] cpu_sp,
  input  logic [15:0] cpu_pc,
  input  logic [23:0] cpu_mem,
  input  logic [7:0]  cpu_flags,
  input  logic        mon_req,
  output logic        mon_gnt,
  input  logic        mon_wr,
  input  logic [2:0]  mon_addr,
  input  logic [15:0] mon_wdata,
  output logic [7:0]  led_a,
  output logic [7:0]  led_x,
  output logic [7:0]  led_y,
  output logic [7:0]  led_data,
  output logic [15:0] led_sp,
  output logic [15:0] led_pc,
  output logic [23:0] led_mem,
  output logic [7:0]  led_flags,
  output logic        leds_valid,
  output logic        src_mon
);

  arb_state_t   state_q, state_d;
  logic         mon_gnt_d;
  logic         load_cpu, load_bank;
  logic         bank_we;
  logic         timeout;
  logic [127:0] bank_flat;
  logic [15:0]  ent_a, ent_x, ent_y, ent_sp, ent_pc, ent_mlo, ent_mhi, ent_fd;

  // Gate on the registered grant so a write on the falling-grant edge lands.
  assign bank_we = mon_wr & mon_gnt;

  override_bank u_bank (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (bank_we),
    .waddr   (mon_addr),
    .wdata   (mon_wdata),
    .rd_flat (bank_flat)
  );

  assign ent_a   = bank_entry(bank_flat, BANK_A);
  assign ent_x   = bank_entry(bank_flat, BANK_X);
  assign ent_y   = bank_entry(bank_flat, BANK_Y);
  assign ent_sp  = bank_entry(bank_flat, BANK_SP);
  assign ent_pc  = bank_entry(bank_flat, BANK_PC);
  assign ent_mlo = bank_entry(bank_flat, BANK_MEM_LO);
  assign ent_mhi = bank_entry(bank_flat, BANK_MEM_HI);
  assign ent_fd  = bank_entry(bank_flat, BANK_FLAGS_DATA);

  // Upper bytes of the narrow entries are storage only, never displayed.
  logic unused_bank_hi;
  assign unused_bank_hi = ^{ent_a[15:8], ent_x[15:8], ent_y[15:8], ent_mhi[15:8]};

`ifdef DISPLAY_ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LIM = 8'(HOLD_FRAMES);

  logic [7:0] idle_cnt_q, idle_cnt_d;

  // Idle-frame counter: counts frame_starts in MON, saturates, cleared by
  // any accepted write (which takes priority over a coincident frame_start).
  always_comb begin
    idle_cnt_d = idle_cnt_q;
    timeout    = 1'b0;
    if (state_q != ST_MON || bank_we) begin
      idle_cnt_d = '0;
    end else if (frame_start) begin
      if (idle_cnt_q < HOLD_LIM) idle_cnt_d = idle_cnt_q + 8'd1;
      if (idle_cnt_q >= HOLD_LIM - 8'd1) timeout = 1'b1;
    end
  end

  // Idle-frame counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) idle_cnt_q <= '0;
    else        idle_cnt_q <= idle_cnt_d;
  end
`else
  assign timeout = 1'b0;
  logic unused_hold;
  assign unused_hold = ^8'(HOLD_FRAMES);
`endif

  // Next-state, grant and output-load selection; everything but LOCKOUT
  // exit waits for frame_start.
  always_comb begin
    state_d   = state_q;
    mon_gnt_d = mon_gnt;
    load_cpu  = 1'b0;
    load_bank = 1'b0;
    case (state_q)
      ST_CPU: begin
        if (frame_start) begin
          load_cpu = 1'b1;
          if (mon_req) state_d = ST_MON_PEND;
        end
      end
      ST_MON_PEND: begin
        if (frame_start) begin
          load_cpu = 1'b1;
          if (mon_req) begin
            state_d   = ST_MON;
            mon_gnt_d = 1'b1;
          end else begin
            state_d = ST_CPU;
          end
        end
      end
      ST_MON: begin
        if (frame_start) begin
          if (timeout) begin
            load_cpu  = 1'b1;
            mon_gnt_d = 1'b0;
            state_d   = ST_LOCKOUT;
          end else begin
            load_bank = 1'b1;
            if (!mon_req) begin
              mon_gnt_d = 1'b0;
              state_d   = ST_CPU;
            end
          end
        end
      end
      ST_LOCKOUT: begin
        load_cpu = frame_start;
        if (!mon_req) state_d = ST_CPU;
      end
      default: state_d = ST_CPU;
    endcase
  end

  // State and grant registers; reset drops the grant immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_CPU;
      mon_gnt <= 1'b0;
    end else begin
      state_q <= state_d;
      mon_gnt <= mon_gnt_d;
    end
  end

  // Display field registers, updated only on frame boundaries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_a      <= '0;
      led_x      <= '0;
      led_y      <= '0;
      led_data   <= '0;
      led_sp     <= '0;
      led_pc     <= '0;
      led_mem    <= '0;
      led_flags  <= '0;
      leds_valid <= 1'b0;
      src_mon    <= 1'b0;
    end else if (load_cpu) begin
      led_a      <= cpu_a;
      led_x      <= cpu_x;
      led_y      <= cpu_y;
      led_data   <= cpu_data;
      led_sp     <= cpu_sp;
      led_pc     <= cpu_pc;
      led_mem    <= cpu_mem;
      led_flags  <= cpu_flags;
      leds_valid <= cpu_valid;
      src_mon    <= 1'b0;
    end else if (load_bank) begin
      led_a      <= ent_a[7:0];
      led_x      <= ent_x[7:0];
      led_y      <= ent_y[7:0];
      led_data   <= ent_fd[7:0];
      led_sp     <= ent_sp;
      led_pc     <= ent_pc;
      led_mem    <= {ent_mhi[7:0], ent_mlo};
      led_flags  <= ent_fd[15:8];
      leds_valid <= 1'b1;
      src_mon    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_display_source_arb.sv
// Directed bench for display_source_arb (HOLD_FRAMES = 3).
module tb_display_source_arb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_start = 1'b0;
  logic        cpu_valid = 1'b0;
  logic [7:0]  cpu_a = '0, cpu_x = '0, cpu_y = '0, cpu_data = '0;
  logic [15:0] cpu_sp = '0, cpu_pc = '0;
  logic [23:0] cpu_mem = '0;
  logic [7:0]  cpu_flags = '0;
  logic        mon_req = 1'b0;
  logic        mon_gnt;
  logic        mon_wr = 1'b0;
  logic [2:0]  mon_addr = '0;
  logic [15:0] mon_wdata = '0;
  logic [7:0]  led_a, led_x, led_y, led_data, led_flags;
  logic [15:0] led_sp, led_pc;
  logic [23:0] led_mem;
  logic        leds_valid, src_mon;

  int n_checks = 0;
  int n_pass   = 0;

  display_source_arb #(.HOLD_FRAMES(3)) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .cpu_valid(cpu_valid),
    .cpu_a(cpu_a), .cpu_x(cpu_x), .cpu_y(cpu_y), .cpu_data(cpu_data),
    .cpu_sp(cpu_sp), .cpu_pc(cpu_pc), .cpu_mem(cpu_mem), .cpu_flags(cpu_flags),
    .mon_req(mon_req), .mon_gnt(mon_gnt), .mon_wr(mon_wr), .mon_addr(mon_addr),
    .mon_wdata(mon_wdata), .led_a(led_a), .led_x(led_x), .led_y(led_y),
    .led_data(led_data), .led_sp(led_sp), .led_pc(led_pc), .led_mem(led_mem),
    .led_flags(led_flags), .leds_valid(leds_valid), .src_mon(src_mon)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic test_reset();
    cpu_valid = 1'b1; cpu_a = 8'h5A; cpu_x = 8'h11; cpu_pc = 16'h1234;
    cpu_sp = 16'h01FD; cpu_mem = 24'hABCDEF; cpu_flags = 8'hA5; cpu_data = 8'h3C;
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(2);
    n_checks++; if (led_a !== 8'h00) $display("FAIL reset_led_a: got %h want %h", led_a, 8'h00); else n_pass++;
    n_checks++; if (leds_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", leds_valid); else n_pass++;
    n_checks++; if (mon_gnt !== 1'b0 || src_mon !== 1'b0) $display("FAIL reset_gnt_src: got %b%b want 00", mon_gnt, src_mon); else n_pass++;
    pulse_frame();
    n_checks++; if (led_a !== 8'h5A) $display("FAIL first_led_a: got %h want %h", led_a, 8'h5A); else n_pass++;
    n_checks++; if (leds_valid !== 1'b1) $display("FAIL first_valid: got %b want 1", leds_valid); else n_pass++;
    n_checks++; if (led_mem !== 24'hABCDEF) $display("FAIL first_led_mem: got %h want %h", led_mem, 24'hABCDEF); else n_pass++;
    n_checks++; if (led_flags !== 8'hA5 || led_data !== 8'h3C) $display("FAIL first_flags_data: got %h %h want a5 3c", led_flags, led_data); else n_pass++;
    n_checks++; if (led_pc !== 16'h1234 || led_sp !== 16'h01FD) $display("FAIL first_pc_sp: got %h %h want 1234 01fd", led_pc, led_sp); else n_pass++;
  endtask

  task automatic test_frame_align();
    tick(2);
    cpu_pc = 16'hBEEF;
    tick(4);
    n_checks++; if (led_pc !== 16'h1234) $display("FAIL midframe_pc: got %h want %h", led_pc, 16'h1234); else n_pass++;
    pulse_frame();
    n_checks++; if (led_pc !== 16'hBEEF) $display("FAIL nextframe_pc: got %h want %h", led_pc, 16'hBEEF); else n_pass++;
  endtask

  task automatic test_grant();
    tick(2);
    mon_req = 1'b1;
    tick(2);
    n_checks++; if (mon_gnt !== 1'b0) $display("FAIL gnt_midframe: got %b want 0", mon_gnt); else n_pass++;
    pulse_frame();
    tick(2);
    n_checks++; if (mon_gnt !== 1'b0) $display("FAIL gnt_after_first_fs: got %b want 0", mon_gnt); else n_pass++;
    pulse_frame();
    n_checks++; if (mon_gnt !== 1'b1) $display("FAIL gnt_after_second_fs: got %b want 1", mon_gnt); else n_pass++;
    n_checks++; if (src_mon !== 1'b0) $display("FAIL src_before_copy: got %b want 0", src_mon); else n_pass++;
    mon_wr = 1'b1; mon_addr = 3'd4; mon_wdata = 16'hC0DE;
    tick();
    mon_addr = 3'd1; mon_wdata = 16'h0033;
    tick();
    mon_wr = 1'b0;
    tick(2);
    n_checks++; if (led_pc !== 16'hBEEF) $display("FAIL pc_before_copy: got %h want %h", led_pc, 16'hBEEF); else n_pass++;
    pulse_frame();
    n_checks++; if (led_pc !== 16'hC0DE) $display("FAIL mon_led_pc: got %h want %h", led_pc, 16'hC0DE); else n_pass++;
    n_checks++; if (src_mon !== 1'b1 || leds_valid !== 1'b1) $display("FAIL mon_src_valid: got %b%b want 11", src_mon, leds_valid); else n_pass++;
    n_checks++; if (led_x !== 8'h33 || led_a !== 8'h00) $display("FAIL mon_led_x_a: got %h %h want 33 00", led_x, led_a); else n_pass++;
  endtask

  task automatic test_coincident_write();
    tick(2);
    mon_wr = 1'b1; mon_addr = 3'd0; mon_wdata = 16'h0077;
    pulse_frame();
    mon_wr = 1'b0;
    n_checks++; if (led_a !== 8'h00) $display("FAIL coinc_old_a: got %h want %h", led_a, 8'h00); else n_pass++;
    tick(2);
    pulse_frame();
    n_checks++; if (led_a !== 8'h77) $display("FAIL coinc_new_a: got %h want %h", led_a, 8'h77); else n_pass++;
  endtask

  task automatic test_release();
    tick(1);
    mon_req = 1'b0;
    tick(1);
    pulse_frame();
    n_checks++; if (mon_gnt !== 1'b0) $display("FAIL release_gnt: got %b want 0", mon_gnt); else n_pass++;
    tick(2);
    pulse_frame();
    n_checks++; if (src_mon !== 1'b0 || led_a !== 8'h5A) $display("FAIL release_cpu: got src %b a %h want 0 5a", src_mon, led_a); else n_pass++;
  endtask

  task automatic test_ignored_write();
    tick(1);
    mon_wr = 1'b1; mon_addr = 3'd1; mon_wdata = 16'h00FF;
    tick();
    mon_wr = 1'b0;
    tick(1);
  endtask

  task automatic test_hold();
    mon_req = 1'b1;
    pulse_frame();
    tick(1);
    pulse_frame();
    n_checks++; if (mon_gnt !== 1'b1) $display("FAIL regrant: got %b want 1", mon_gnt); else n_pass++;
    tick(1);
    pulse_frame();
    n_checks++; if (led_x !== 8'h33) $display("FAIL ignored_wr_x: got %h want %h", led_x, 8'h33); else n_pass++;
    tick(1);
    pulse_frame();
    n_checks++; if (mon_gnt !== 1'b1) $display("FAIL idle2_gnt: got %b want 1", mon_gnt); else n_pass++;
    tick(1);
    pulse_frame();
`ifdef DISPLAY_ARB_TIMEOUT_EN
    n_checks++; if (mon_gnt !== 1'b0) $display("FAIL timeout_gnt: got %b want 0", mon_gnt); else n_pass++;
    n_checks++; if (src_mon !== 1'b0 || led_a !== 8'h5A) $display("FAIL timeout_cpu: got src %b a %h want 0 5a", src_mon, led_a); else n_pass++;
    tick(1);
    pulse_frame();
    tick(1);
    pulse_frame();
    n_checks++; if (mon_gnt !== 1'b0) $display("FAIL lockout_hold: got %b want 0", mon_gnt); else n_pass++;
    mon_req = 1'b0;
    tick();
    mon_req = 1'b1;
    tick(1);
    pulse_frame();
    n_checks++; if (mon_gnt !== 1'b0) $display("FAIL lockout_pend: got %b want 0", mon_gnt); else n_pass++;
    tick(1);
    pulse_frame();
    n_checks++; if (mon_gnt !== 1'b1) $display("FAIL lockout_regrant: got %b want 1", mon_gnt); else n_pass++;
`else
    n_checks++; if (mon_gnt !== 1'b1) $display("FAIL hold_gnt: got %b want 1", mon_gnt); else n_pass++;
    n_checks++; if (src_mon !== 1'b1 || led_a !== 8'h77) $display("FAIL hold_bank: got src %b a %h want 1 77", src_mon, led_a); else n_pass++;
`endif
  endtask

  task automatic test_reset_mid_grant();
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (mon_gnt !== 1'b0) $display("FAIL async_rst_gnt: got %b want 0", mon_gnt); else n_pass++;
    n_checks++; if (led_pc !== 16'h0000 || leds_valid !== 1'b0) $display("FAIL async_rst_out: got %h %b want 0000 0", led_pc, leds_valid); else n_pass++;
    mon_req = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2);
  endtask

  initial begin
    test_reset();
    test_frame_align();
    test_grant();
    test_coincident_write();
    test_release();
    test_ignored_write();
    test_hold();
    test_reset_mid_grant();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
